// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC iteration controller: atan table, gain constant and FSM states.
package cordic_pkg;

   localparam int unsigned LUT_DEPTH = 32;

   // Q2.30 reciprocal of the CORDIC gain
   localparam logic [31:0] K_Q30 = 32'h26DD3B6A;

   // atan(2^-i) in angle units where 2^32 is one full turn
   localparam logic [31:0] ATAN_LUT [0:LUT_DEPTH-1] = '{
      32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
      32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
      32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
      32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
      32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
      32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
      32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
      32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
   };

   typedef enum logic [1:0] {
      IDLE,
      PRESCALE,
      ITER,
      DONE
   } state_e;

endpackage

// File: rtl/cordic_barrel_shift.sv
// Arithmetic right shifter for the per-iteration x/y shift terms of the CORDIC datapath.
module cordic_barrel_shift #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SH_W  = 5
) (
   input  logic [WIDTH-1:0] din,
   input  logic [SH_W-1:0]  shamt,
   output logic [WIDTH-1:0] dout
);

   always_comb begin
      dout = $signed(din) >>> shamt;
   end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// CORDIC iteration sequencer: issues one ALU pass per cycle and returns the final vector.
// Define CORDIC_GAIN_COMP_EN to add a one-cycle PRESCALE pass that removes the CORDIC gain.
module cordic_iter_ctrl
   import cordic_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned N_ITER = 16,
   parameter int unsigned CNT_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   input  logic [WIDTH-1:0] in_target,
   input  logic [3:0]       in_select,
   output logic [WIDTH-1:0] alu_x_init,
   output logic [WIDTH-1:0] alu_y_init,
   output logic [WIDTH-1:0] alu_x_shift,
   output logic [WIDTH-1:0] alu_y_shift,
   output logic [WIDTH-1:0] alu_angle,
   output logic [WIDTH-1:0] alu_delta,
   output logic [WIDTH-1:0] alu_target,
   output logic [3:0]       alu_select,
   output logic             alu_valid,
   input  logic [WIDTH-1:0] alu_x_res,
   input  logic [WIDTH-1:0] alu_y_res,
   input  logic [WIDTH-1:0] alu_angle_res,
   input  logic [3:0]       alu_select_res,
   input  logic             alu_valid_res,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_x,
   output logic [WIDTH-1:0] out_y,
   output logic [WIDTH-1:0] out_angle,
   output logic [3:0]       out_select
);

   localparam logic [CNT_W-1:0] LAST_I = CNT_W'(N_ITER - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] i_q, i_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
   logic [WIDTH-1:0] angle_q, angle_d, target_q, target_d;
   logic [3:0]       select_q, select_d;
   logic [WIDTH-1:0] x_shift, y_shift;
   logic             unused_select_res;

`ifdef CORDIC_GAIN_COMP_EN
   function automatic logic [WIDTH-1:0] gain_scale(input logic [WIDTH-1:0] v);
      logic signed [2*WIDTH-1:0] prod;
      prod = $signed({{WIDTH{v[WIDTH-1]}}, v}) * $signed({{WIDTH{1'b0}}, WIDTH'(K_Q30)});
      return prod[WIDTH+29:30];
   endfunction
`endif

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      x_d      = x_q;
      y_d      = y_q;
      angle_d  = angle_q;
      target_d = target_q;
      select_d = select_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d      = in_x;
               y_d      = in_y;
               angle_d  = '0;
               target_d = in_target;
               select_d = in_select;
               i_d      = '0;
`ifdef CORDIC_GAIN_COMP_EN
               state_d  = PRESCALE;
`else
               state_d  = ITER;
`endif
            end
         end
         PRESCALE: begin
`ifdef CORDIC_GAIN_COMP_EN
            x_d = gain_scale(x_q);
            y_d = gain_scale(y_q);
`endif
            state_d = ITER;
         end
         ITER: begin
            // a missing ALU result freezes the whole pass, counter included
            if (alu_valid_res) begin
               x_d     = alu_x_res;
               y_d     = alu_y_res;
               angle_d = alu_angle_res;
               if (i_q == LAST_I) begin
                  state_d = DONE;
               end else begin
                  i_d = i_q + CNT_W'(1);
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         i_q      <= '0;
         x_q      <= '0;
         y_q      <= '0;
         angle_q  <= '0;
         target_q <= '0;
         select_q <= '0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         x_q      <= x_d;
         y_q      <= y_d;
         angle_q  <= angle_d;
         target_q <= target_d;
         select_q <= select_d;
      end
   end

   cordic_barrel_shift #(.WIDTH(WIDTH), .SH_W(CNT_W)) u_shift_x (
      .din   (x_q),
      .shamt (i_q),
      .dout  (x_shift)
   );

   cordic_barrel_shift #(.WIDTH(WIDTH), .SH_W(CNT_W)) u_shift_y (
      .din   (y_q),
      .shamt (i_q),
      .dout  (y_shift)
   );

   assign in_ready    = (state_q == IDLE);
   assign alu_valid   = (state_q == ITER);
   assign out_valid   = (state_q == DONE);
   assign alu_x_init  = x_q;
   assign alu_y_init  = y_q;
   assign alu_x_shift = x_shift;
   assign alu_y_shift = y_shift;
   assign alu_angle   = angle_q;
   assign alu_delta   = WIDTH'(ATAN_LUT[i_q]);
   assign alu_target  = target_q;
   assign alu_select  = select_q;
   assign out_x       = x_q;
   assign out_y       = y_q;
   assign out_angle   = angle_q;
   assign out_select  = select_q;

   assign unused_select_res = ^alu_select_res;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: plays the ALU stage and checks every cycle against a job-level CORDIC model.
module tb_cordic_iter_ctrl;

   localparam int N_ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int PRE = 1;
`else
   localparam int PRE = 0;
`endif
   localparam logic [31:0] K_Q30 = 32'h26DD3B6A;
   localparam int PH_IDLE = 0;
   localparam int PH_WORK = 1;
   localparam int PH_DONE = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] in_x, in_y, in_target;
   logic [3:0]  in_select;
   logic [31:0] alu_x_init, alu_y_init, alu_x_shift, alu_y_shift;
   logic [31:0] alu_angle, alu_delta, alu_target;
   logic [3:0]  alu_select, alu_select_res;
   logic        alu_valid, alu_valid_res;
   logic [31:0] alu_x_res, alu_y_res, alu_angle_res;
   logic        out_valid, out_ready;
   logic [31:0] out_x, out_y, out_angle;
   logic [3:0]  out_select;
   logic        stall;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] lut [0:31];
   logic [31:0] lut_sum;
   logic [31:0] hx [0:N_ITER-1];
   logic [31:0] hy [0:N_ITER-1];
   logic [31:0] ha [0:N_ITER-1];
   logic [31:0] fx, fy, fa, m_target;
   logic [3:0]  m_sel;

   bit m_live = 1'b0;
   int m_phase = PH_IDLE;
   bit m_pre = 1'b0;
   int m_left = 0;
   bit m_zero = 1'b0;

   always #5 clk = ~clk;

   cordic_iter_ctrl #(.WIDTH(32), .N_ITER(N_ITER), .CNT_W(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_x           (in_x),
      .in_y           (in_y),
      .in_target      (in_target),
      .in_select      (in_select),
      .alu_x_init     (alu_x_init),
      .alu_y_init     (alu_y_init),
      .alu_x_shift    (alu_x_shift),
      .alu_y_shift    (alu_y_shift),
      .alu_angle      (alu_angle),
      .alu_delta      (alu_delta),
      .alu_target     (alu_target),
      .alu_select     (alu_select),
      .alu_valid      (alu_valid),
      .alu_x_res      (alu_x_res),
      .alu_y_res      (alu_y_res),
      .alu_angle_res  (alu_angle_res),
      .alu_select_res (alu_select_res),
      .alu_valid_res  (alu_valid_res),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_x          (out_x),
      .out_y          (out_y),
      .out_angle      (out_angle),
      .out_select     (out_select)
   );

   // One CORDIC micro-rotation: rotate towards the target unless select bit 3 forces positive.
   function automatic logic [95:0] rot(input logic [31:0] x, y, xs, ys, a, d, t,
                                       input logic [3:0] sel);
      logic [31:0] r;
      r = t - a;
      if (sel[3] || !r[31]) return {x - ys, y + xs, a + d};
      return {x + ys, y - xs, a - d};
   endfunction

   always_comb begin
      {alu_x_res, alu_y_res, alu_angle_res} = rot(alu_x_init, alu_y_init, alu_x_shift, alu_y_shift,
                                                  alu_angle, alu_delta, alu_target, alu_select);
      alu_select_res = alu_select;
      alu_valid_res  = alu_valid && !stall;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_tol(input string name, input logic [31:0] act, input logic [31:0] exp,
                          input longint tol);
      longint d;
      d = longint'($signed(act)) - longint'($signed(exp));
      if (d < 0) d = -d;
      n_checks++;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h +/- %0d at %0t", name, act, exp, tol, $time);
      end
   endtask

   // Whole-job reference: per-iteration register history and final vector.
   task automatic ref_job(input logic [31:0] x0, y0, t, input logic [3:0] sel);
      logic [31:0] x, y, a;
      longint p;
      x = x0;
      y = y0;
      a = '0;
`ifdef CORDIC_GAIN_COMP_EN
      p = longint'($signed(x)) * longint'(K_Q30);
      x = 32'(p >>> 30);
      p = longint'($signed(y)) * longint'(K_Q30);
      y = 32'(p >>> 30);
`endif
      for (int i = 0; i < N_ITER; i++) begin
         hx[i] = x;
         hy[i] = y;
         ha[i] = a;
         {x, y, a} = rot(x, y, 32'($signed(x) >>> i), 32'($signed(y) >>> i), a, lut[i], t, sel);
      end
      fx = x;
      fy = y;
      fa = a;
      m_target = t;
      m_sel = sel;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_live  <= 1'b1;
         m_phase <= PH_IDLE;
         m_pre   <= 1'b0;
         m_left  <= 0;
         m_zero  <= 1'b1;
      end else begin
         case (m_phase)
            PH_IDLE: if (in_valid) begin
               m_phase <= PH_WORK;
               m_pre   <= (PRE != 0);
               m_left  <= N_ITER;
               m_zero  <= 1'b0;
            end
            PH_WORK: begin
               if (m_pre) m_pre <= 1'b0;
               else if (!stall) begin
                  m_left <= m_left - 1;
                  if (m_left == 1) m_phase <= PH_DONE;
               end
            end
            default: if (out_ready) m_phase <= PH_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         int idx;
         chk("in_ready", 32'(in_ready), 32'(m_phase == PH_IDLE));
         chk("alu_valid", 32'(alu_valid), 32'(m_phase == PH_WORK && !m_pre));
         chk("out_valid", 32'(out_valid), 32'(m_phase == PH_DONE));
         if (m_phase == PH_WORK && !m_pre) begin
            idx = N_ITER - m_left;
            chk("alu_x_init", alu_x_init, hx[idx]);
            chk("alu_y_init", alu_y_init, hy[idx]);
            chk("alu_angle", alu_angle, ha[idx]);
            chk("alu_x_shift", alu_x_shift, 32'($signed(hx[idx]) >>> idx));
            chk("alu_y_shift", alu_y_shift, 32'($signed(hy[idx]) >>> idx));
            chk("alu_delta", alu_delta, lut[idx]);
            chk("alu_target", alu_target, m_target);
            chk("alu_select", 32'(alu_select), 32'(m_sel));
         end
         if (m_phase == PH_DONE) begin
            chk("out_x", out_x, fx);
            chk("out_y", out_y, fy);
            chk("out_angle", out_angle, fa);
            chk("out_select", 32'(out_select), 32'(m_sel));
         end
         if (m_zero) begin
            chk("zero_alu_x", alu_x_init, '0);
            chk("zero_alu_target", alu_target, '0);
            chk("zero_out_y", out_y, '0);
            chk("zero_out_angle", out_angle, '0);
            chk("zero_out_select", 32'(out_select), '0);
         end
      end
   end

   task automatic accept(input logic [31:0] x, y, t, input logic [3:0] sel);
      ref_job(x, y, t, sel);
      in_x = x;
      in_y = y;
      in_target = t;
      in_select = sel;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
   endtask

   // Starts 2 time units after the accept edge; lat counts cycles from the accept cycle.
   task automatic wait_done(input int stall_at, input bit busy, output int lat);
      int e;
      bit done;
      e = 0;
      done = 1'b0;
      while (!done && e < 300) begin
         stall = (stall_at >= 0) && (e >= stall_at + PRE) && (e < stall_at + PRE + 3);
         in_valid = busy && (e == 2 || e == 5);
         in_x = ~in_x;
         in_select = ~in_select;
         @(posedge clk);
         e++;
         #1;
         if (out_valid) done = 1'b1;
         #1;
      end
      in_valid = 1'b0;
      stall = 1'b0;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL out_valid_timeout: got none expected within 300 cycles");
      end
      lat = e + 1;
   endtask

   initial begin
      int lat;
      real pi;
      pi = $atan(1.0) * 4.0;
      lut_sum = '0;
      for (int i = 0; i < 32; i++) begin
         lut[i] = 32'(longint'($atan(2.0 ** (-i)) / (2.0 * pi) * 4294967296.0));
         if (i < N_ITER) lut_sum = lut_sum + lut[i];
      end

      rst = 1'b1;
      in_valid = 1'b0;
      in_x = '0;
      in_y = '0;
      in_target = '0;
      in_select = '0;
      out_ready = 1'b1;
      stall = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_alu_valid", 32'(alu_valid), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_x", out_x, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #2;

      // 45 degree rotation of the pre-scaled unit vector, with busy-time in_valid pulses
      accept(32'h26DD3B6A, 32'h0, 32'h20000000, 4'b0101);
      wait_done(-1, 1'b1, lat);
      chk("lat_basic", 32'(lat), 32'(N_ITER + 1 + PRE));
`ifndef CORDIC_GAIN_COMP_EN
      chk_tol("t1_out_x", out_x, 32'h2D413CCD, 64'd16384);
      chk_tol("t1_out_y", out_y, 32'h2D413CCD, 64'd16384);
      chk_tol("t1_out_angle", out_angle, 32'h20000000, 64'd262144);
`endif
      chk("t1_out_select", 32'(out_select), 32'h5);
      repeat (4) @(posedge clk);
      #2;

      // forced positive rotations accumulate the whole table
      accept(32'h12345678, 32'hF5432110, 32'h70000000, 4'b1000);
      wait_done(-1, 1'b0, lat);
      chk("t2_out_angle", out_angle, lut_sum);
      chk("t2_out_select", 32'(out_select), 32'h8);
      @(posedge clk);
      #2;

      // zero-angle target: y tolerance covers the final residual angle
      accept(32'h40000000, 32'h0, 32'h0, 4'b0000);
      wait_done(-1, 1'b0, lat);
`ifdef CORDIC_GAIN_COMP_EN
      chk_tol("t3_out_x", out_x, 32'h40000000, 64'd16384);
`else
      chk_tol("t3_out_x", out_x, 32'd1768195363, 64'd16384);
`endif
      chk_tol("t3_out_y", out_y, 32'h0, 64'd32768);
      @(posedge clk);
      #2;

      // downstream backpressure, then handshake coinciding with a new request
      out_ready = 1'b0;
      accept(32'h20000000, 32'h10000000, 32'hE0000000, 4'b0011);
      wait_done(-1, 1'b0, lat);
      chk("lat_bp", 32'(lat), 32'(N_ITER + 1 + PRE));
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_x", out_x, fx);
         #1;
      end
      out_ready = 1'b1;
      in_x = 32'h0C000000;
      in_y = 32'h33333333;
      in_target = 32'h0AAAAAAA;
      in_select = 4'b0111;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("hs_in_ready", 32'(in_ready), 32'd1);
      chk("hs_out_valid", 32'(out_valid), 32'd0);
      ref_job(32'h0C000000, 32'h33333333, 32'h0AAAAAAA, 4'b0111);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      chk("hs_accepted", 32'(in_ready), 32'd0);
      wait_done(-1, 1'b0, lat);
      chk("lat_hs", 32'(lat), 32'(N_ITER + 1 + PRE));
      @(posedge clk);
      #2;

      // three stalled ALU cycles at i=4
      accept(32'h30000000, 32'h08000000, 32'h15555555, 4'b0110);
      wait_done(4, 1'b0, lat);
      chk("lat_stall", 32'(lat), 32'(N_ITER + 1 + PRE + 3));
      @(posedge clk);
      #2;

      // reset in the middle of iteration i=7
      accept(32'h2AAAAAAA, 32'hF0000000, 32'h40000000, 4'b0001);
      repeat (7 + PRE) @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_alu_valid", 32'(alu_valid), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_x", out_x, 32'd0);
      chk("mid_rst_alu_angle", alu_angle, 32'd0);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
